sipo_word_rx: RTL and testbench
===============================

// Module: sipo_word_rx
// PURPOSE
//   Serial-in/parallel-out word receiver; downstream partner of the 4-bit piso_sr transmitter.
//   Samples serial_in on each clk edge where shift_en=1 and assembles WIDTH bits into a word.
//   Presents each completed word in a one-entry output buffer with a valid/ready handshake.
//   Flags overrun when a word completes while the buffer is still unconsumed.
// PARAMETERS
//   WIDTH      4  word length in bits (>=2); matches piso_sr data_in width
//   MSB_FIRST  1  1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0]
// PORTS
//   clk         in   1      single clock, all state updates on rising edge
//   reset       in   1      asynchronous, active-high; clears all state
//   shift_en    in   1      serial_in is a valid bit this cycle
//   serial_in   in   1      serial data bit
//   sync_clr    in   1      synchronous word realign: discard partial word, clear overrun
//   data_ready  in   1      consumer accepts data_out this cycle when data_valid=1
//   data_out    out  WIDTH  last completed word (registered)
//   data_valid  out  1      data_out holds an unconsumed word
//   overrun     out  1      sticky: a completed word was dropped
//   bit_cnt     out  CNT_W  bits received in current word, 0..WIDTH-1 (CNT_W=$clog2(WIDTH))
// BEHAVIOUR
//   Reset: sr, bit_cnt, data_out, data_valid, overrun all 0; buffer FSM -> EMPTY. Effective immediately, mid-word or not.
//   Shifter, per edge, priority sync_clr > shift_en:
//     sync_clr=1: sr<=0, bit_cnt<=0, overrun<=0; serial_in ignored; output buffer untouched.
//     shift_en=1: MSB_FIRST ? sr<={sr[WIDTH-2:0],serial_in} : sr<={serial_in,sr[WIDTH-1:1]}.
//       bit_cnt<=bit_cnt+1, except when bit_cnt==WIDTH-1 -> wraps to 0 and asserts internal word_done.
//       word = next-state value of sr (includes the bit sampled this edge).
//     shift_en=0: shifter holds.
//   Output buffer FSM (EMPTY: data_valid=0, FULL: data_valid=1):
//     EMPTY & word_done                 -> FULL, data_out<=word.
//     FULL & data_ready & word_done     -> FULL, data_out<=word (back-to-back, no bubble).
//     FULL & data_ready & !word_done    -> EMPTY; data_out holds its last value.
//     FULL & !data_ready & word_done    -> FULL, data_out unchanged, new word dropped, overrun<=1.
//     FULL & !data_ready & !word_done   -> FULL, hold.
//   Latency: data_valid rises on the same edge that samples the WIDTH-th bit; 0 extra cycles.
//   Throughput: one bit per clk; a new word every WIDTH cycles with shift_en held high.
//   data_ready with data_valid=0 is ignored.
//   overrun is cleared only by reset or sync_clr. sync_clr in the same cycle as a set condition: clear wins.
//   sync_clr with shift_en=1 on the last bit: no word_done; partial word discarded.
//   shift_en gaps mid-word: bits accumulate across gaps; no timeout.
// STRUCTURE
//   Package sipo_pkg: WIDTH default constant, CNT_W derivation, buffer state encoding (EMPTY=1'b0, FULL=1'b1).
//   Sub-module sipo_out_buf: the one-entry valid/ready buffer with overrun logic.
//     Top level keeps the shift register and bit counter and drives word/word_done into it.
// TESTING (WIDTH=4, clk period 10ns)
//   1 MSB_FIRST=1, data_ready=1; shift_en=1, serial_in 1,1,0,1 on 4 edges
//     -> data_out=4'b1101, data_valid=1 after 4th edge, 0 one cycle later; bit_cnt 1,2,3,0.
//   2 MSB_FIRST=0, same bit sequence -> data_out=4'b1011.
//   3 data_ready=0; send 1101 then 0110 continuously
//     -> data_out stays 1101, data_valid=1, overrun=1 after 8th bit.
//     Then data_ready=1 one cycle -> data_valid=0; sync_clr=1 -> overrun=0.
//   4 Send 1,0 then sync_clr=1, then 0,0,1,1
//     -> bit_cnt=0 after clear; data_out=4'b0011; no word from the 2 discarded bits.
//   5 reset=1 asynchronously mid-word (bit_cnt=2, data_valid=1)
//     -> all outputs 0 immediately, before the next edge; next 4 bits 1,0,0,1 -> 4'b1001.
//   6 Loopback with upstream piso_sr: load 4'b1101, shift 4 cycles
//     -> data_out=4'b1101, data_valid=1 exactly once.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and types for the serial-in/parallel-out word receiver.
package sipo_pkg;

    // Word length used when the receiver is paired with the 4-bit piso_sr.
    localparam int SIPO_DEFAULT_WIDTH = 4;

    // Output buffer occupancy: EMPTY means no unconsumed word is held.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Width of the bit counter; never below one bit so the port stays legal.
    function automatic int cntWidth(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready output buffer with sticky overrun detection.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_sync_clr,
    input  logic             i_word_done,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_data_ready,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_data_valid,
    output logic             o_overrun
);

    buf_state_t       r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_overrun;

    // Buffer FSM: capture completed words, release on handshake, flag words dropped while full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= BUF_EMPTY;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (i_word_done) begin
                        r_state <= BUF_FULL;
                        r_data  <= i_word;
                    end
                end
                BUF_FULL: begin
                    if (i_data_ready) begin
                        if (i_word_done) begin
                            r_data <= i_word;
                        end else begin
                            r_state <= BUF_EMPTY;
                        end
                    end else if (i_word_done) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= BUF_EMPTY;
            endcase
            if (i_sync_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data_out   = r_data;
    assign o_data_valid = (r_state == BUF_FULL);
    assign o_overrun    = r_overrun;

endmodule

// File: rtl/sipo_word_rx.sv
// Serial-in/parallel-out word receiver: shift register and bit counter feeding a one-entry buffer.
module sipo_word_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          shift_en,
    input  logic                          serial_in,
    input  logic                          sync_clr,
    input  logic                          data_ready,
    output logic [WIDTH-1:0]              data_out,
    output logic                          data_valid,
    output logic                          overrun,
    output logic [cntWidth(WIDTH)-1:0]    bit_cnt
);

    localparam int               CNT_W = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_sr_next;
    logic             w_last_bit;
    logic             w_word_done;

    // The first bit received ends up at the top for MSB-first and at bit 0 for LSB-first.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sr_next = {r_sr[WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign w_sr_next = {serial_in, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // A word completes on the edge that samples its last bit; realign suppresses it.
    assign w_last_bit  = (r_cnt == LAST);
    assign w_word_done = shift_en && !sync_clr && w_last_bit;

    // Shifter and bit counter; realign takes priority over shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (shift_en) begin
            r_sr  <= w_sr_next;
            r_cnt <= w_last_bit ? '0 : r_cnt + CNT_W'(1);
        end
    end

    sipo_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk          (clk),
        .reset        (reset),
        .i_sync_clr   (sync_clr),
        .i_word_done  (w_word_done),
        .i_word       (w_sr_next),
        .i_data_ready (data_ready),
        .o_data_out   (data_out),
        .o_data_valid (data_valid),
        .o_overrun    (overrun)
    );

    assign bit_cnt = r_cnt;

endmodule

// File: tb/tb_sipo_word_rx.sv
// Testbench for sipo_word_rx: MSB-first and LSB-first instances driven in parallel against a bit-queue model.
module tb_sipo_word_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       shiftEn = 1'b0;
    logic       serialIn = 1'b0;
    logic       syncClr = 1'b0;
    logic       dataReady = 1'b0;

    logic [3:0] dataOutM, dataOutL;
    logic       dataValidM, dataValidL;
    logic       overrunM, overrunL;
    logic [1:0] bitCntM, bitCntL;

    int         testsRun = 0;
    int         testsFailed = 0;

    // Reference model: bits of the current partial word in arrival order, plus buffer contents.
    bit         rxBits[$];
    bit         expValid = 1'b0;
    bit         expOvr = 1'b0;
    logic [3:0] expDataM = 4'b0;
    logic [3:0] expDataL = 4'b0;
    int         validCycles;
    logic [3:0] pisoReg;

    always #5 clk = ~clk;

    sipo_word_rx #(.WIDTH(4), .MSB_FIRST(1)) dutMsb (
        .clk(clk), .reset(reset), .shift_en(shiftEn), .serial_in(serialIn),
        .sync_clr(syncClr), .data_ready(dataReady), .data_out(dataOutM),
        .data_valid(dataValidM), .overrun(overrunM), .bit_cnt(bitCntM)
    );

    sipo_word_rx #(.WIDTH(4), .MSB_FIRST(0)) dutLsb (
        .clk(clk), .reset(reset), .shift_en(shiftEn), .serial_in(serialIn),
        .sync_clr(syncClr), .data_ready(dataReady), .data_out(dataOutL),
        .data_valid(dataValidL), .overrun(overrunL), .bit_cnt(bitCntL)
    );

    // Single comparison point with failure counting.
    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic checkOutput(input string tag);
        checkValue({tag, ".dataM"},  32'(dataOutM),   32'(expDataM));
        checkValue({tag, ".dataL"},  32'(dataOutL),   32'(expDataL));
        checkValue({tag, ".validM"}, 32'(dataValidM), 32'(expValid));
        checkValue({tag, ".validL"}, 32'(dataValidL), 32'(expValid));
        checkValue({tag, ".ovrM"},   32'(overrunM),   32'(expOvr));
        checkValue({tag, ".ovrL"},   32'(overrunL),   32'(expOvr));
        checkValue({tag, ".cntM"},   32'(bitCntM),    32'(rxBits.size()));
        checkValue({tag, ".cntL"},   32'(bitCntL),    32'(rxBits.size()));
    endtask

    // Advance the model by one clock edge from the receiver's rules.
    task automatic modelEdge(input bit en, input bit b, input bit clr, input bit rdy);
        bit         done = 1'b0;
        logic [3:0] wordM = 4'b0;
        logic [3:0] wordL = 4'b0;
        if (clr) begin
            rxBits.delete();
            expOvr = 1'b0;
        end else if (en) begin
            rxBits.push_back(b);
            if (rxBits.size() == 4) begin
                done = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    wordM = wordM + (4'(rxBits[i]) << (3 - i));
                    wordL = wordL + (4'(rxBits[i]) << i);
                end
                rxBits.delete();
            end
        end
        if (!expValid) begin
            if (done) begin
                expValid = 1'b1;
                expDataM = wordM;
                expDataL = wordL;
            end
        end else if (rdy) begin
            if (done) begin
                expDataM = wordM;
                expDataL = wordL;
            end else begin
                expValid = 1'b0;
            end
        end else if (done) begin
            expOvr = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, then check after the edge.
    task automatic applyStimulus(input bit en, input bit b, input bit clr, input bit rdy, input string tag);
        shiftEn   = en;
        serialIn  = b;
        syncClr   = clr;
        dataReady = rdy;
        @(posedge clk);
        modelEdge(en, b, clr, rdy);
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic asyncReset(input string tag);
        #2;
        reset = 1'b1;
        rxBits.delete();
        expValid = 1'b0;
        expOvr   = 1'b0;
        expDataM = 4'b0;
        expDataL = 4'b0;
        #1;
        checkOutput(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] seqA;
        logic [3:0] seqB;

        // Power-on reset.
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("resetRelease");

        // Bits 1,1,0,1 with the consumer always ready.
        seqA = 4'b1101;
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, seqA[i], 1'b0, 1'b1, "basic");
        checkValue("basicWordMsb", 32'(dataOutM), 32'h0000000d);
        checkValue("basicWordLsb", 32'(dataOutL), 32'h0000000b);
        checkValue("basicValid", 32'(dataValidM), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "basicDrain");
        checkValue("basicDrained", 32'(dataValidM), 32'h0);

        // Consumer stalled across two words: second word is dropped.
        seqB = 4'b0110;
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, seqA[i], 1'b0, 1'b0, "stallA");
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, seqB[i], 1'b0, 1'b0, "stallB");
        checkValue("overrunSet", 32'(overrunM), 32'h1);
        checkValue("overrunKeep", 32'(dataOutM), 32'h0000000d);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "overrunDrain");
        checkValue("overrunDrained", 32'(dataValidM), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "overrunClr");
        checkValue("overrunCleared", 32'(overrunM), 32'h0);

        // Realign discards a partial word.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "realign");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "realign");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "realignClr");
        checkValue("realignCnt", 32'(bitCntM), 32'h0);
        seqA = 4'b0011;
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, seqA[i], 1'b0, 1'b1, "realignWord");
        checkValue("realignWordMsb", 32'(dataOutM), 32'h00000003);

        // Realign on the last bit of a word suppresses the word.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "lastBitDrain");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "lastBit");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "lastBitClr");
        checkValue("lastBitNoWord", 32'(dataValidM), 32'h0);

        // Async reset mid-word with a word pending.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'(i), 1'b0, 1'b0, "preReset");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "preReset");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "preReset");
        checkValue("preResetCnt", 32'(bitCntM), 32'h2);
        asyncReset("midReset");
        seqA = 4'b1001;
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, seqA[i], 1'b0, 1'b1, "postReset");
        checkValue("postResetWord", 32'(dataOutM), 32'h00000009);

        // Loopback from an MSB-first parallel-in serial-out source.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "loopIdle");
        pisoReg = 4'b1101;
        validCycles = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i < 4, pisoReg[3], 1'b0, 1'b1, "loop");
            if (i < 4) pisoReg = {pisoReg[2:0], 1'b0};
            if (dataValidM) validCycles++;
            if (i == 3) checkValue("loopWord", 32'(dataOutM), 32'h0000000d);
        end
        checkValue("loopOnce", 32'(validCycles), 32'h1);

        // Randomized traffic including gaps, stalls and occasional realigns.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom),
                          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
